// File: rtl/led_pwm_pkg.sv
// Shared constants and helpers for the red-LED PWM dimmer/blinker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package led_pwm_pkg;

    localparam int LED_W  = 10;
    localparam int PWM_W  = 8;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_BRIGHT = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK   = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_RSVD   = 2'd3;

    localparam logic [PWM_W-1:0] BRIGHT_RST = 8'hFF;
    localparam logic [PWM_W-1:0] PWM_MAX    = 8'hFF;

    // Snapshot of the control state used for a whole PWM period.
    typedef struct packed {
        logic [LED_W-1:0] pattern;
        logic [PWM_W-1:0] bright;
        logic [LED_W-1:0] mask;
    } act_t;

    // Per-LED on condition: pattern gated by duty compare and blink blanking.
    // Full brightness bypasses the compare so the duty cycle reaches 100%.
    function automatic logic [LED_W-1:0] led_drive(
        input act_t             act,
        input logic [PWM_W-1:0] cnt,
        input logic             phase
    );
        logic duty_on;
        duty_on = (act.bright == PWM_MAX) || (cnt < act.bright);
        return act.pattern & {LED_W{duty_on}} & ~(act.mask & {LED_W{phase}});
    endfunction

    // Status word: blink phase at bit 8, current PWM count below it.
    function automatic logic [DATA_W-1:0] status_word(
        input logic             phase,
        input logic [PWM_W-1:0] cnt
    );
        return {{(DATA_W-PWM_W-1){1'b0}}, phase, cnt};
    endfunction

endpackage

// File: rtl/system_0_led_red_pwm_if.sv
// Avalon-MM slave bus of the LED PWM block (word addressed, no wait states).
// Latency: readdata is combinational from address.
// Backpressure: none; every access completes in the cycle it is presented.
interface system_0_led_red_pwm_if;

    logic [led_pwm_pkg::ADDR_W-1:0] address;
    logic                           chipselect;
    logic                           write_n;
    logic [led_pwm_pkg::DATA_W-1:0] writedata;
    logic [led_pwm_pkg::DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler, 8-bit PWM counter, period_start pulse, blink phase.
// Latency: period_start is combinational from the registered counters.
// Backpressure: none; free-running. Blink logic only with LED_PWM_BLINK_EN.
module led_pwm_timebase
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE      = 195,
    parameter int BLINK_PERIODS = 250
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [PWM_W-1:0] pwm_cnt,
    output logic             period_start,
    output logic             blink_phase
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescaler;
    logic            tick;

    assign tick         = (prescaler == PS_LAST);
    assign period_start = tick && (pwm_cnt == PWM_MAX);

    // Prescaler counts 0..PRESCALE-1 and restarts on its terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // PWM step counter advances once per tick and wraps 255 -> 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

`ifdef LED_PWM_BLINK_EN
    localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_PERIODS - 1);

    logic [BL_W-1:0] blink_cnt;

    // Count whole PWM periods; flip the blink phase each time the count wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (period_start) begin
            if (blink_cnt == BL_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    assign blink_phase = 1'b0;
`endif

endmodule

// File: rtl/system_0_led_red_pwm.sv
// Red-LED dimmer/blinker: Avalon register file, per-period active copies, PWM compare.
// Latency: led_out is registered, one clk after pwm_cnt; readdata combinational.
// Backpressure: none (zero-wait-state slave). Blink feature: LED_PWM_BLINK_EN.
module system_0_led_red_pwm
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE      = 195,
    parameter int BLINK_PERIODS = 250
) (
    input  logic                        clk,
    input  logic                        reset_n,
    system_0_led_red_pwm_if.slave       bus,
    input  logic [LED_W-1:0]            pattern_in,
    output logic [LED_W-1:0]            led_out
);

    logic [PWM_W-1:0] pwm_cnt;
    logic             period_start;
    logic             blink_phase;

    logic             wr_en;
    logic [PWM_W-1:0] brightness;
    logic [LED_W-1:0] blink_mask;
    act_t             act;
    logic             unused_wdata;

    led_pwm_timebase #(
        .PRESCALE      (PRESCALE),
        .BLINK_PERIODS (BLINK_PERIODS)
    ) u_timebase (
        .clk          (clk),
        .reset_n      (reset_n),
        .pwm_cnt      (pwm_cnt),
        .period_start (period_start),
        .blink_phase  (blink_phase)
    );

    assign wr_en = bus.chipselect && !bus.write_n;

    // Only the low bits of each register are stored; the rest of the bus is dropped.
    assign unused_wdata = ^bus.writedata[DATA_W-1:PWM_W];

    // Brightness register, reset to full on so LEDs follow the PIO by default.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            brightness <= BRIGHT_RST;
        end else if (wr_en && (bus.address == ADDR_BRIGHT)) begin
            brightness <= bus.writedata[PWM_W-1:0];
        end
    end

`ifdef LED_PWM_BLINK_EN
    // Blink mask register selects which LEDs are blanked in the off phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask <= '0;
        end else if (wr_en && (bus.address == ADDR_MASK)) begin
            blink_mask <= bus.writedata[LED_W-1:0];
        end
    end

    // Active mask only changes at a period boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act.mask <= '0;
        end else if (period_start) begin
            act.mask <= blink_mask;
        end
    end
`else
    assign blink_mask = '0;
    assign act.mask   = '0;
`endif

    // Snapshot pattern and brightness at the period boundary so a period is never cut short.
    // A write landing on the boundary edge is seen only at the following boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act.pattern <= '0;
            act.bright  <= BRIGHT_RST;
        end else if (period_start) begin
            act.pattern <= pattern_in;
            act.bright  <= brightness;
        end
    end

    // Register the compare result so the pins see clean, glitch-free levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= '0;
        end else begin
            led_out <= led_drive(act, pwm_cnt, blink_phase);
        end
    end

    // Read mux; unused and reserved locations return zero.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_BRIGHT: bus.readdata = {{(DATA_W-PWM_W){1'b0}}, brightness};
            ADDR_MASK:   bus.readdata = {{(DATA_W-LED_W){1'b0}}, blink_mask};
            ADDR_STATUS: bus.readdata = status_word(blink_phase, pwm_cnt);
            ADDR_RSVD:   bus.readdata = '0;
            default:     bus.readdata = '0;
        endcase
    end

endmodule
